// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, instruction width and PC step.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_pkg;

    localparam int          ILEN   = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, registered instruction to decode.
// Latency: grant edge to instrValid equals memory response latency; peak 1 instr / 2 cycles.
// Backpressure: no request while holding an unconsumed stalled instruction; redirect beats stall.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imemReq,
    output logic [31:0]      imemAddr,
    input  logic             imemGnt,
    input  logic             imemRvalid,
    input  logic [ILEN-1:0]  imemRdata,
    output logic [ILEN-1:0]  instruction,
    output logic [31:0]      instructionPc,
    output logic             instrValid,
    input  logic             stall,
    input  logic             redirectValid,
    input  logic [31:0]      redirectPc
);

    fetch_state_t state, state_nxt;

    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic        drop;

    logic room;
    logic grant;
    logic redirect_act;
    logic load;

    // Room in the output register: empty, or being drained this cycle.
    assign room         = !instrValid || !stall;
    assign grant        = imemReq && imemGnt;
    // Redirects are meaningless before the first fetch has been armed.
    assign redirect_act = redirectValid && (state != IDLE);
    // A response is kept only if it belongs to the current path.
    assign load         = (state == WAIT) && imemRvalid && !drop && !redirectValid;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: any response (kept or discarded) closes the outstanding request.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     state_nxt = grant ? WAIT : REQ;
            WAIT:    state_nxt = imemRvalid ? REQ : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // Request outputs: a redirect suppresses the request so the next one uses the new pc.
    always_comb begin
        imemReq  = (state == REQ) && room && !redirectValid;
        imemAddr = pc;
    end

    // Datapath: pc, in-flight address, drop flag and the decode-facing register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            fetch_pc      <= 32'h0;
            drop          <= 1'b0;
            instruction   <= '0;
            instructionPc <= 32'h0;
            instrValid    <= 1'b0;
        end else begin
            if (grant) begin
                fetch_pc <= pc;
            end

            if (redirect_act) begin
                pc <= word_align(redirectPc);
            end else if (load) begin
                pc <= fetch_pc + PC_INC;
            end

            // A redirect while waiting marks the in-flight response as stale.
            if (state == WAIT) begin
                if (imemRvalid) begin
                    drop <= 1'b0;
                end else if (redirectValid) begin
                    drop <= 1'b1;
                end
            end

            if (load) begin
                instruction   <= imemRdata;
                instructionPc <= fetch_pc;
            end

            if (redirect_act) begin
                instrValid <= 1'b0;
            end else if (load) begin
                instrValid <= 1'b1;
            end else if (instrValid && !stall) begin
                instrValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async reset sequence, random run vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_stage;

    localparam logic [31:0] RP = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic [31:0] instruction;
    logic [31:0] instructionPc;
    logic        instrValid;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectPc;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage #(.RESET_PC(RP)) dut (
        .clk           (clk),
        .rst           (rst),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemGnt       (imemGnt),
        .imemRvalid    (imemRvalid),
        .imemRdata     (imemRdata),
        .instruction   (instruction),
        .instructionPc (instructionPc),
        .instrValid    (instrValid),
        .stall         (stall),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stl;
        logic        rdv;
        logic [31:0] rdpc;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] instr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic s, input logic rdv, input logic [31:0] rdp);
        imemGnt       = g;
        imemRvalid    = rv;
        imemRdata     = rd;
        stall         = s;
        redirectValid = rdv;
        redirectPc    = rdp;
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] hashf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Hold reset for two edges and release it on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'h0, imemReq},    32'h0);
        chk({tag, "_addr"},  imemAddr,            RP);
        chk({tag, "_iv"},    {31'h0, instrValid}, 32'h0);
        chk({tag, "_ipc"},   instructionPc,       32'h0);
        chk({tag, "_instr"}, instruction,         32'h0);
    endtask

    localparam logic [31:0] A1 = 32'hAAAA_0001;
    localparam logic [31:0] C3 = 32'hCCCC_0003;
    localparam logic [31:0] D4 = 32'hDDDD_0004;
    localparam logic [31:0] WR = 32'hFFFF_FFFC;

    initial begin
        // gnt rv rdata stall rdv rdpc | req addr iv ipc instr
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        0, RP,         0, 32'h0, 32'h0});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        1, RP,         0, 32'h0, 32'h0});
        tbl.push_back('{1, 1, A1,           0, 0, 32'h0,        0, RP,         0, 32'h0, 32'h0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1, 0, 32'h0,    1, 0, 32'h0,        0, RP + 32'd4, 1, RP,    A1});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        1, RP + 32'd4, 1, RP,    A1});
        tbl.push_back('{1, 0, 32'h0,        0, 1, 32'h0000_1002, 0, RP + 32'd4, 0, RP,    A1});
        tbl.push_back('{1, 1, 32'hBAD0_BAD0, 0, 0, 32'h0,       0, 32'h1000,   0, RP,    A1});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h1000,   0, RP,    A1});
        tbl.push_back('{1, 1, 32'hBAD1_BAD1, 0, 1, 32'hFFFF_FFFE, 0, 32'h1000, 0, RP,    A1});
        tbl.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, WR,         0, RP,    A1});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        1, WR,         0, RP,    A1});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        0, WR,         0, RP,    A1});
        tbl.push_back('{1, 1, C3,           0, 0, 32'h0,        0, WR,         0, RP,    A1});
        tbl.push_back('{0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,      1, WR,    C3});
        tbl.push_back('{1, 0, 32'h0,        0, 1, 32'h0000_2000, 0, 32'h0,     0, WR,    C3});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h2000,   0, WR,    C3});
        tbl.push_back('{1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h2000,   0, WR,    C3});

        // ---------------- directed table ----------------
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #3;
        check_reset_outputs("rst_init");
        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].stl, tbl[i].rdv, tbl[i].rdpc);
            #1;
            chk($sformatf("row%0d_req", i),   {31'h0, imemReq},    {31'h0, tbl[i].req});
            chk($sformatf("row%0d_addr", i),  imemAddr,            tbl[i].addr);
            chk($sformatf("row%0d_iv", i),    {31'h0, instrValid}, {31'h0, tbl[i].iv});
            chk($sformatf("row%0d_ipc", i),   instructionPc,       tbl[i].ipc);
            chk($sformatf("row%0d_instr", i), instruction,         tbl[i].instr);
            @(posedge clk);
            @(negedge clk);
        end

        // ---------------- async reset while waiting ----------------
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 32'h0, 0, 1, 32'h0000_5000);   // redirect while IDLE: ignored
        #1;
        chk("idle_req", {31'h0, imemReq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("refetch_req",  {31'h0, imemReq}, 32'h1);
        chk("refetch_addr", imemAddr, RP);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, D4, 0, 0, 32'h0);
        #1;
        chk("refetch_wait_req", {31'h0, imemReq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        chk("refetch_iv",    {31'h0, instrValid}, 32'h1);
        chk("refetch_ipc",   instructionPc, RP);
        chk("refetch_instr", instruction, D4);
        chk("refetch_next",  imemAddr, RP + 32'd4);

        // ---------------- random run against stream model ----------------
        begin
            int          pend = 0;
            logic [31:0] pend_addr = 32'h0;
            logic [31:0] exp_pc = RP;
            logic        prev_hold = 1'b0;
            logic [31:0] prev_instr = 32'h0;
            logic [31:0] prev_ipc = 32'h0;
            int          n_consumed = 0;
            logic        rv, g, s, rdv;
            logic [31:0] rd, rdp;

            do_reset();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                rv = 1'b0;
                rd = $urandom;
                if (pend == 1) begin
                    rv = 1'b1;
                    rd = hashf(pend_addr);
                    pend = 0;
                end else if (pend > 1) begin
                    pend--;
                end
                g   = ($urandom_range(0, 1) == 1);
                s   = ($urandom_range(0, 2) == 0);
                rdv = (cyc >= 2) && ($urandom_range(0, 11) == 0);
                rdp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
                drive(g, rv, rd, s, rdv, rdp);
                #1;

                chk("addr_align", {30'h0, imemAddr[1:0]}, 32'h0);
                if (pend != 0 || rv)
                    chk("one_outstanding", {31'h0, imemReq}, 32'h0);
                if (instrValid && s)
                    chk("stall_no_req", {31'h0, imemReq}, 32'h0);
                if (prev_hold) begin
                    chk("hold_iv",    {31'h0, instrValid}, 32'h1);
                    chk("hold_instr", instruction, prev_instr);
                    chk("hold_ipc",   instructionPc, prev_ipc);
                end

                if (instrValid && !s) begin
                    chk("cons_pc",   instructionPc, exp_pc);
                    chk("cons_data", instruction, hashf(instructionPc));
                    exp_pc = exp_pc + 32'd4;
                    n_consumed++;
                end
                if (rdv)
                    exp_pc = rdp & ~32'd3;
                if (imemReq && g) begin
                    pend      = $urandom_range(1, 3);
                    pend_addr = imemAddr;
                end
                prev_hold  = instrValid && s && !rdv;
                prev_instr = instruction;
                prev_ipc   = instructionPc;

                @(posedge clk);
                @(negedge clk);
            end
            chk("progress", {31'h0, (n_consumed >= 100)}, 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 Port imemReq  output  1  SHALL be the instruction-memory request valid.
REQ-005 Port imemAddr  output  32  SHALL be the request address, word-aligned.
REQ-006 Port imemGnt  input  1  SHALL be request accepted; transfer occurs when imemReq && imemGnt.
REQ-007 Port imemRvalid  input  1  SHALL be response valid: exactly one per grant, in order, at least 1 cycle after grant.
REQ-008 Port imemRdata  input  32  SHALL be the response instruction word.
REQ-009 Port instruction  output  32  SHALL be the registered instruction fed to decode/immediate generation.
REQ-010 Port instructionPc  output  32  SHALL be the address of instruction.
REQ-011 Port instrValid  output  1  SHALL flag instruction/instructionPc valid.
REQ-012 Port stall  input  1  SHALL be decode back-pressure; instruction consumed on an edge where instrValid && !stall.
REQ-013 Port redirectValid  input  1  SHALL be a branch/jump redirect strobe.
REQ-014 Port redirectPc  input  32  SHALL be the redirect target.

Function
REQ-015 FSM states IDLE, REQ, WAIT; at most one request outstanding.
REQ-016 IDLE -> REQ on the first edge after rst deasserts; imemReq=0 in IDLE.
REQ-017 Room = !instrValid || !stall; imemReq = (state==REQ) && room && !redirectValid; imemAddr = pc.
REQ-018 REQ -> WAIT on grant; fetchPc <= pc at that edge; otherwise stay in REQ with pc unchanged.
REQ-019 WAIT, imemRvalid with drop=0: instruction <= imemRdata, instructionPc <= fetchPc, instrValid <= 1, pc <= fetchPc + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), -> REQ.
REQ-020 WAIT, imemRvalid with drop=1: response discarded, outputs unchanged, drop <= 0, -> REQ.
REQ-021 Consumption without a new load SHALL clear instrValid; while instrValid && stall, instruction, instructionPc and instrValid SHALL hold.
REQ-022 Minimum fetch latency: grant edge to instrValid high = response latency; peak throughput one instruction per 2 cycles.
REQ-023 redirectValid (any state but IDLE): pc <= {redirectPc[31:2], 2'b00}, instrValid <= 0 next edge, regardless of stall (redirect beats stall).
REQ-024 Redirect in WAIT without same-cycle imemRvalid: drop <= 1, stay WAIT.
REQ-025 Redirect in WAIT with same-cycle imemRvalid: that response discarded, drop stays 0, -> REQ.
REQ-026 Redirect in REQ: no request issued that cycle; next request uses the new pc.
REQ-027 Redirect in IDLE SHALL be ignored.

Reset
REQ-028 On rst: state=IDLE, pc=RESET_PC, fetchPc=0, drop=0, instruction=32'h0, instructionPc=32'h0, instrValid=0, imemReq=0, imemAddr=RESET_PC.
REQ-029 rst mid-transaction SHALL abandon the outstanding request; memory SHALL not deliver responses to pre-reset grants.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the fetch-state enum and ILEN=32 / PC_INC=4 constants.
REQ-031 Single module; no sub-module required.

Verification
REQ-032 Reset, imemGnt=1, 1-cycle response: first imemAddr=RESET_PC; instrValid at cycle 3 with instructionPc=RESET_PC; next imemAddr=RESET_PC+4.
REQ-033 instrValid=1, stall held 5 cycles: outputs stable, imemReq=0 throughout; stall drop -> request issued same cycle.
REQ-034 Redirect to 32'h0000_1002 while WAIT: late response discarded, instrValid stays 0, next imemAddr=32'h0000_1000.
REQ-035 Redirect coincident with imemRvalid: data never appears on instruction; next imemAddr=redirect target.
REQ-036 pc=32'hFFFF_FFFC fetch completes: next imemAddr=32'h0000_0000.
REQ-037 rst asserted in WAIT: outputs return to reset values asynchronously; refetch starts at RESET_PC.
